// File: rtl/width_conv_pkg.sv
// rtl/width_conv_pkg.sv - mode and ratio helpers for the stream width converter
package width_conv_pkg;

  typedef enum logic [1:0] {
    MODE_PASS,
    MODE_UP,
    MODE_DOWN
  } conv_mode_e;

  function automatic conv_mode_e conv_mode(int iw, int ow);
    if (ow > iw) return MODE_UP;
    if (iw > ow) return MODE_DOWN;
    return MODE_PASS;
  endfunction

  function automatic int conv_ratio(int iw, int ow);
    if (ow > iw) return ow / iw;
    if (iw > ow) return iw / ow;
    return 1;
  endfunction

  // Slot/chunk counters never shrink below one bit, even for a 1:1 ratio.
  function automatic int cnt_width(int ratio);
    return (ratio > 1) ? $clog2(ratio) : 1;
  endfunction

endpackage

// File: rtl/width_conv_out_slice.sv
// rtl/width_conv_out_slice.sv - one-deep output register with valid/ready
module width_conv_out_slice #(
  parameter int DW = 64,
  parameter int KW = 1
) (
  input  logic          I_Clk,
  input  logic          I_Rst_n,
  input  logic          load_valid,
  input  logic [DW-1:0] load_data,
  input  logic [KW-1:0] load_keep,
  input  logic          load_last,
  output logic          load_en,
  input  logic          beat_ready,
  output logic          beat_valid,
  output logic [DW-1:0] beat_data,
  output logic [KW-1:0] beat_keep,
  output logic          beat_last
);

  // The register may take a new beat whenever it is empty or being drained.
  assign load_en = ~beat_valid | beat_ready;

  always_ff @(posedge I_Clk or negedge I_Rst_n) begin
    if (!I_Rst_n) begin
      beat_valid <= 1'b0;
      beat_data  <= '0;
      beat_keep  <= '0;
      beat_last  <= 1'b0;
    end else if (load_en) begin
      beat_valid <= load_valid;
      if (load_valid) begin
        beat_data <= load_data;
        beat_keep <= load_keep;
        beat_last <= load_last;
      end
    end
  end

endmodule

// File: rtl/data_width_conv.sv
// rtl/data_width_conv.sv - MSB-first stream upsizer/downsizer/register slice
module data_width_conv
  import width_conv_pkg::*;
#(
  parameter int IW_WIDTH = 32,
  parameter int OW_WIDTH = 64,
  localparam int KW = (OW_WIDTH > IW_WIDTH) ? OW_WIDTH / IW_WIDTH : 1
) (
  input  logic                I_Clk,
  input  logic                I_Rst_n,
  input  logic                I_Data_De,
  input  logic [IW_WIDTH-1:0] I_Data,
  input  logic                I_Data_Last,
  output logic                O_In_Rdy,
  output logic                O_Data_De,
  output logic [OW_WIDTH-1:0] O_Data,
  output logic [KW-1:0]       O_Data_Keep,
  output logic                O_Data_Last,
  input  logic                I_Out_Rdy
);

  localparam conv_mode_e MODE  = conv_mode(IW_WIDTH, OW_WIDTH);
  localparam int         RATIO = conv_ratio(IW_WIDTH, OW_WIDTH);
  localparam int         CW    = cnt_width(RATIO);

  if (IW_WIDTH < 1 || OW_WIDTH < 1 ||
      ((IW_WIDTH % OW_WIDTH) != 0 && (OW_WIDTH % IW_WIDTH) != 0)) begin : g_bad_ratio
    $error("data_width_conv: IW_WIDTH and OW_WIDTH must be integer multiples of each other");
  end

  if (MODE == MODE_UP) begin : g_up
    logic                         load_en;
    logic                         in_fire;
    logic                         done;
    logic [OW_WIDTH-IW_WIDTH-1:0] acc;
    logic [CW-1:0]                cnt;
    logic [OW_WIDTH-1:0]          acc_next;
    logic [OW_WIDTH-1:0]          word;
    logic [KW-1:0]                keep;

    assign O_In_Rdy = I_Rst_n & load_en;
    assign in_fire  = I_Data_De & O_In_Rdy;
    assign done     = in_fire & ((cnt == CW'(RATIO - 1)) | I_Data_Last);
    assign acc_next = {acc, I_Data};
    // Left-justify a short word: empty low slots become zero with keep cleared.
    assign word     = acc_next << (IW_WIDTH * (RATIO - 1 - int'(cnt)));
    assign keep     = {KW{1'b1}} << (RATIO - 1 - int'(cnt));

    always_ff @(posedge I_Clk or negedge I_Rst_n) begin
      if (!I_Rst_n) begin
        acc <= '0;
        cnt <= '0;
      end else if (done) begin
        acc <= '0;
        cnt <= '0;
      end else if (in_fire) begin
        acc <= acc_next[OW_WIDTH-IW_WIDTH-1:0];
        cnt <= cnt + CW'(1);
      end
    end

    width_conv_out_slice #(.DW(OW_WIDTH), .KW(KW)) u_slice (
      .I_Clk      (I_Clk),
      .I_Rst_n    (I_Rst_n),
      .load_valid (done),
      .load_data  (word),
      .load_keep  (keep),
      .load_last  (I_Data_Last),
      .load_en    (load_en),
      .beat_ready (I_Out_Rdy),
      .beat_valid (O_Data_De),
      .beat_data  (O_Data),
      .beat_keep  (O_Data_Keep),
      .beat_last  (O_Data_Last)
    );
  end else if (MODE == MODE_DOWN) begin : g_down
    logic                load_en;
    logic                more;
    logic [CW-1:0]       chunk;
    logic [IW_WIDTH-1:0] hold;
    logic                held_last;
    logic [IW_WIDTH-1:0] load_data;
    logic                load_last;

    // While chunks remain, the slice reloads itself with the shifted word.
    assign more      = O_Data_De & (chunk != CW'(RATIO - 1));
    assign load_data = more ? {hold[IW_WIDTH-OW_WIDTH-1:0], {OW_WIDTH{1'b0}}} : I_Data;
    assign load_last = more ? held_last : I_Data_Last;
    assign O_In_Rdy  = I_Rst_n & load_en & ~more;

    assign O_Data      = hold[IW_WIDTH-1 -: OW_WIDTH];
    assign O_Data_Last = held_last & (chunk == CW'(RATIO - 1));

    always_ff @(posedge I_Clk or negedge I_Rst_n) begin
      if (!I_Rst_n) begin
        chunk <= '0;
      end else if (load_en) begin
        chunk <= more ? chunk + CW'(1) : '0;
      end
    end

    width_conv_out_slice #(.DW(IW_WIDTH), .KW(1)) u_slice (
      .I_Clk      (I_Clk),
      .I_Rst_n    (I_Rst_n),
      .load_valid (more | I_Data_De),
      .load_data  (load_data),
      .load_keep  (1'b1),
      .load_last  (load_last),
      .load_en    (load_en),
      .beat_ready (I_Out_Rdy),
      .beat_valid (O_Data_De),
      .beat_data  (hold),
      .beat_keep  (O_Data_Keep),
      .beat_last  (held_last)
    );
  end else begin : g_pass
    logic load_en;

    assign O_In_Rdy = I_Rst_n & load_en;

    width_conv_out_slice #(.DW(OW_WIDTH), .KW(1)) u_slice (
      .I_Clk      (I_Clk),
      .I_Rst_n    (I_Rst_n),
      .load_valid (I_Data_De),
      .load_data  (I_Data),
      .load_keep  (1'b1),
      .load_last  (I_Data_Last),
      .load_en    (load_en),
      .beat_ready (I_Out_Rdy),
      .beat_valid (O_Data_De),
      .beat_data  (O_Data),
      .beat_keep  (O_Data_Keep),
      .beat_last  (O_Data_Last)
    );
  end

endmodule

// File: doc/data_width_conv.md
# data_width_conv

Parametrised stream width converter with valid/ready flow control, replacing the fixed upsizing concatenator in the DMA data path. It packs narrow beats into wide words (upsize), splits wide words into narrow beats (downsize), or acts as a one-deep register slice when widths match. It supports back-pressure and early word termination via a last flag with a slot keep mask. It sits between the DMA read/write engines and the AXI data channels.

## Interface
- IW_WIDTH, 32, input beat width; must be a nonzero integer multiple or divisor of OW_WIDTH (elaboration error otherwise)
- OW_WIDTH, 64, output beat width
- KW (derived, not overridable), OW_WIDTH/IW_WIDTH when upsizing, else 1; keep-mask width
- I_Clk  in  1  clock; everything rising-edge
- I_Rst_n  in  1  reset; asynchronous, active-low
- I_Data_De  in  1  input beat valid
- I_Data  in  IW_WIDTH  input beat
- I_Data_Last  in  1  input beat ends a packet
- O_In_Rdy  out  1  block accepts input this cycle; transfer = I_Data_De & O_In_Rdy
- O_Data_De  out  1  output beat valid
- O_Data  out  OW_WIDTH  output beat
- O_Data_Keep  out  KW  per-IW-slot valid mask; bit KW-1 = first slot, MSB side
- O_Data_Last  out  1  output beat ends a packet
- I_Out_Rdy  in  1  downstream accepts; transfer = O_Data_De & I_Out_Rdy

## Operation
- Mode fixed at elaboration: UP (OW>IW, N=OW/IW), DOWN (IW>OW, M=IW/OW), PASS (equal).
- Ordering is MSB-first in every mode: the first narrow beat occupies the most significant slot.
- UP:
  - Accumulator shifts left by IW on each input transfer; slot counter runs 0..N-1.
  - A transfer with counter = N-1 or I_Data_Last=1 completes the word. On completion, the word is loaded into the output register, left-justified: unfilled low slots are zero and their keep bits are 0. O_Data_Last = last of the completing beat. Counter and accumulator clear.
  - O_In_Rdy = ~O_Data_De | I_Out_Rdy. Stalled output blocks all input, including non-completing beats.
- DOWN:
  - Hold register plus chunk counter 0..M-1.
  - O_In_Rdy = ~O_Data_De | (I_Out_Rdy & chunk = M-1).
  - O_Data = top OW bits of the hold register. Each output transfer shifts it left by OW and increments the chunk counter.
  - O_Data_Last = held last & chunk = M-1. O_Data_Keep = 1.
- PASS: single register slice. O_In_Rdy = ~O_Data_De | I_Out_Rdy. Keep = 1. Last passes through.
- An output beat, once valid, holds O_Data, O_Data_Keep and O_Data_Last stable until it is accepted.
- Reset:
  - All registers clear, including counters and accumulator. O_Data_De=0, O_Data=0, O_Data_Keep=0, O_Data_Last=0.
  - O_In_Rdy is forced to 0 while I_Rst_n=0 and is 1 in the first cycle after release.
  - Reset mid-word discards the partial word; no beat is emitted for it.

## Timing
- UP: completing input transfer at edge t gives O_Data_De=1 after edge t. Sustains 1 input beat per cycle with I_Out_Rdy held high.
- DOWN: input transfer at edge t gives the first chunk valid after edge t. A new word loads on the same edge that the last chunk transfers, so chunks are back-to-back with no gap.
- PASS: 1 cycle latency, full throughput.
- Simultaneous output accept and completing input (UP/PASS), or last-chunk accept and new input (DOWN): the new beat loads and O_Data_De stays 1 with no bubble.
- Counter width is $clog2 of the ratio, minimum 1.

## Structure
- Package width_conv_pkg:
  - enum conv_mode_e {MODE_PASS, MODE_UP, MODE_DOWN}
  - function conv_mode(iw, ow)
  - function conv_ratio(iw, ow)
- Sub-module width_conv_out_slice: one-deep output register holding data/keep/last with valid/ready. Shared by all three modes. Exports a load-enable signal equal to ~valid | ready.

## Test plan
- UP 32→64: in 0x11111111, 0x22222222, I_Out_Rdy=1 -> one beat 0x1111111122222222, keep 2'b11, last 0, one cycle after the second beat.
- UP 32→64 early last: in 0xA, 0xB, 0xC (last) -> 0x0000000A0000000B keep 11 last 0, then 0x0000000C00000000 keep 10 last 1.
- UP stall: hold I_Out_Rdy=0 after the first completed word -> O_In_Rdy=0 and the output is stable. Release -> the next word follows with no loss and no duplication.
- DOWN 64→16: in 0x0123456789ABCDEF (last), I_Out_Rdy=1 -> 0x0123, 0x4567, 0x89AB, 0xCDEF on consecutive cycles, last only on 0xCDEF. A second input word offered continuously is accepted on the 0xCDEF cycle, with no bubble.
- PASS 32→32 with random I_Out_Rdy toggling -> output stream equals input stream, and no beat is ever accepted while O_In_Rdy=0.
- Reset mid-word (UP 32→128 after 2 beats): assert I_Rst_n=0 -> all outputs 0 immediately. After release, 4 beats 1,2,3,4 -> a single word 0x00000001000000020000000300000004, keep 4'b1111.
